vga_frame_swap_ctrl: RTL
========================

Name: vga_frame_swap_ctrl

Overview:
Sequences double-buffer swaps on the VGA pixel DMA by driving its 32-bit control slave as an Avalon-MM master. A requester hands over a new frame-buffer base address. The block then writes it to the back-buffer register, triggers the swap, and polls the swap-pending status bit until the DMA takes the swap at vertical sync. It reports completion or timeout. It sits between the HPS/Nios-side frame producer and the pixel DMA control slave, in the sys_clk domain.

Parameters:
MAX_POLLS, 4096, status reads allowed before declaring a timeout (≥2)
POLL_GAP, 15, idle cycles between successive status reads (≥0)
FRONT_RESET, 32'h0000_0000, reset value of front_addr

Ports:
sys_clk_clk  in  1  single clock, all logic rising-edge
sys_reset_reset_n  in  1  synchronous active-low reset
swap_valid  in  1  request strobe; accepted when swap_valid && swap_ready
swap_addr  in  32  new frame-buffer base; sampled on accept
swap_ready  out  1  high only in IDLE
swap_done  out  1  1-cycle pulse, swap taken
swap_timeout  out  1  1-cycle pulse, MAX_POLLS exhausted
timeout_flag  out  1  sticky error; cleared on next accepted request
front_addr  out  32  last successfully swapped base address
ctl_address  out  2  to pixel_dma_control_slave_address
ctl_byteenable  out  4  to pixel_dma_control_slave_byteenable
ctl_read  out  1  to pixel_dma_control_slave_read
ctl_write  out  1  to pixel_dma_control_slave_write
ctl_writedata  out  32  to pixel_dma_control_slave_writedata
ctl_readdata  in  32  from pixel_dma_control_slave_readdata

Behaviour:
- Reset is synchronous and active-low. While sys_reset_reset_n=0 at a rising edge, the FSM goes to IDLE and outputs take these values: swap_ready=1 (after reset), swap_done=0, swap_timeout=0, timeout_flag=0, front_addr=FRONT_RESET, ctl_read=0, ctl_write=0, ctl_address=0, ctl_byteenable=0, ctl_writedata=0. The poll and gap counters clear.
- Reset mid-operation aborts the current operation. No further bus cycles are issued. Any half-done swap is abandoned, and front_addr is not updated.
- Slave model: no waitrequest; each write takes one cycle; read data is valid exactly 1 cycle after ctl_read. Register map: 0 = front buffer (any write triggers a swap), 1 = back buffer, 3 = status, where bit0 = swap pending.
- All ctl_* outputs are registered. ctl_byteenable=4'hF whenever read or write is high, otherwise 0. ctl_read and ctl_write are never high together.
- FSM states:
  - IDLE: swap_ready=1. On accept, latch swap_addr into pend_addr, clear timeout_flag and poll_cnt, then go to WR_BACK.
  - WR_BACK: ctl_write=1, address=1, writedata=pend_addr, for one cycle, then WR_SWAP.
  - WR_SWAP: ctl_write=1, address=0, writedata=32'h1, for one cycle, then POLL_RD.
  - POLL_RD: ctl_read=1, address=3, for one cycle, then POLL_CAP.
  - POLL_CAP: sample ctl_readdata[0] and increment poll_cnt.
    - bit0=0: go to DONE.
    - else if poll_cnt (pre-increment) == MAX_POLLS-1: go to TMO.
    - else: go to GAP, or straight to POLL_RD if POLL_GAP=0.
  - GAP: count POLL_GAP cycles, then POLL_RD.
  - DONE: front_addr<=pend_addr, swap_done=1 for one cycle, then IDLE.
  - TMO: swap_timeout=1 for one cycle, timeout_flag<=1, front_addr unchanged, then IDLE.
- Latency: with no pending status on the first read, a swap takes accept→swap_done = 5 cycles (WR_BACK, WR_SWAP, POLL_RD, POLL_CAP, DONE). Each extra poll adds POLL_GAP+2 cycles.
- A request arriving when swap_ready=0 is not accepted; the requester holds swap_valid. There is no queueing, and at most one swap is outstanding.
- swap_valid held high through DONE is accepted again on the first IDLE cycle, i.e. back-to-back swaps with a 1-cycle IDLE gap.
- Only bit0 of ctl_readdata is used; the other bits are ignored.
- poll_cnt is wide enough for MAX_POLLS and never wraps.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with swap_valid=1 → swap_ready=1 after release, front_addr=0, no ctl_read/ctl_write during reset; accept happens on the first cycle after release.
- Immediate swap: swap_addr=32'h0800_0000, status bit0=0 on the first read → write(1, 0x08000000), write(0, 0x1), read(3), swap_done 5 cycles after accept, front_addr=0x08000000.
- Delayed vsync: status bit0=1 for 3 reads, then 0, POLL_GAP=15 → exactly 4 reads spaced 17 cycles apart, then swap_done; no timeout.
- Timeout: MAX_POLLS=4, status stuck at 1 → exactly 4 reads, swap_timeout pulse, timeout_flag=1, front_addr unchanged. Next accepted request clears timeout_flag.
- Back-to-back: swap_valid held with addr A then B → two complete sequences, swap_ready low throughout each, final front_addr=B; a request while busy is not accepted.
- Reset mid-poll: assert reset_n=0 during GAP → next cycle ctl_read=0, FSM in IDLE, front_addr=FRONT_RESET, no swap_done or swap_timeout pulse.

Source files
------------

// File: rtl/vga_frame_swap_ctrl_if.sv
// Purpose: request handshake plus pixel-DMA control-slave bus for the frame swap sequencer.
// Latency: none, wiring only.
// Backpressure: swap_valid is held by the requester until swap_ready; the control slave never stalls.
interface vga_frame_swap_ctrl_if;
  logic        swap_valid;
  logic [31:0] swap_addr;
  logic        swap_ready;
  logic        swap_done;
  logic        swap_timeout;
  logic        timeout_flag;
  logic [31:0] front_addr;
  logic [1:0]  ctl_address;
  logic [3:0]  ctl_byteenable;
  logic        ctl_read;
  logic        ctl_write;
  logic [31:0] ctl_writedata;
  logic [31:0] ctl_readdata;

  // Sequencer side: accepts requests, masters the control bus.
  modport master (
    input  swap_valid, swap_addr, ctl_readdata,
    output swap_ready, swap_done, swap_timeout, timeout_flag, front_addr,
           ctl_address, ctl_byteenable, ctl_read, ctl_write, ctl_writedata
  );

  // Environment side: frame producer plus the DMA control slave.
  modport slave (
    output swap_valid, swap_addr, ctl_readdata,
    input  swap_ready, swap_done, swap_timeout, timeout_flag, front_addr,
           ctl_address, ctl_byteenable, ctl_read, ctl_write, ctl_writedata
  );
endinterface

// File: rtl/vga_frame_swap_ctrl.sv
// Purpose: writes a new back-buffer base to the pixel DMA, triggers the swap, polls until vsync takes it.
// Latency: accept to swap_done is 5 cycles when the first status read shows no pending swap; +POLL_GAP+2 per extra poll.
// Backpressure: swap_ready is high only in IDLE; one swap outstanding, no queueing.
module vga_frame_swap_ctrl #(
  parameter int          MAX_POLLS   = 4096,
  parameter int          POLL_GAP    = 15,
  parameter logic [31:0] FRONT_RESET = 32'h0000_0000
) (
  input  logic                        sys_clk_clk,
  input  logic                        sys_reset_reset_n,
  vga_frame_swap_ctrl_if.master       bus
);

  localparam int PCW = $clog2(MAX_POLLS + 1);
  localparam int GCW = $clog2(POLL_GAP + 1) + 1;

  localparam logic [1:0] REG_FRONT  = 2'd0;
  localparam logic [1:0] REG_BACK   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd3;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_BACK  = 3'd1,
    WR_SWAP  = 3'd2,
    POLL_RD  = 3'd3,
    POLL_CAP = 3'd4,
    GAP      = 3'd5,
    DONE     = 3'd6,
    TMO      = 3'd7
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic [31:0]      pend_addr;
  logic [PCW-1:0]   poll_cnt;
  logic [GCW-1:0]   gap_cnt;

  // Next-state decode; the status bit is only meaningful in POLL_CAP, one cycle after the read strobe.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.swap_valid) begin
          accept    = 1'b1;
          state_nxt = WR_BACK;
        end
      end
      WR_BACK:  state_nxt = WR_SWAP;
      WR_SWAP:  state_nxt = POLL_RD;
      POLL_RD:  state_nxt = POLL_CAP;
      POLL_CAP: begin
        if (!bus.ctl_readdata[0]) begin
          state_nxt = DONE;
        end else if (poll_cnt == PCW'(MAX_POLLS - 1)) begin
          state_nxt = TMO;
        end else if (POLL_GAP == 0) begin
          state_nxt = POLL_RD;
        end else begin
          state_nxt = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == GCW'(POLL_GAP - 1)) begin
          state_nxt = POLL_RD;
        end
      end
      DONE:    state_nxt = IDLE;
      TMO:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge sys_clk_clk) begin
    if (!sys_reset_reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Request capture, poll/gap counters, front buffer and sticky timeout tracking.
  always_ff @(posedge sys_clk_clk) begin
    if (!sys_reset_reset_n) begin
      pend_addr        <= 32'h0;
      poll_cnt         <= '0;
      gap_cnt          <= '0;
      bus.front_addr   <= FRONT_RESET;
      bus.timeout_flag <= 1'b0;
    end else begin
      if (accept) begin
        pend_addr        <= bus.swap_addr;
        poll_cnt         <= '0;
        bus.timeout_flag <= 1'b0;
      end else if (state == POLL_CAP) begin
        poll_cnt <= poll_cnt + 1'b1;
      end
      // gap_cnt runs only while waiting between polls and restarts at zero on each entry.
      if (state == GAP) begin
        gap_cnt <= gap_cnt + 1'b1;
      end else begin
        gap_cnt <= '0;
      end
      if (state_nxt == DONE) begin
        bus.front_addr <= pend_addr;
      end
      if (state_nxt == TMO) begin
        bus.timeout_flag <= 1'b1;
      end
    end
  end

  // Registered outputs, decoded from the state being entered so they line up with that state.
  always_ff @(posedge sys_clk_clk) begin
    if (!sys_reset_reset_n) begin
      bus.swap_ready     <= 1'b1;
      bus.swap_done      <= 1'b0;
      bus.swap_timeout   <= 1'b0;
      bus.ctl_read       <= 1'b0;
      bus.ctl_write      <= 1'b0;
      bus.ctl_address    <= 2'd0;
      bus.ctl_byteenable <= 4'h0;
      bus.ctl_writedata  <= 32'h0;
    end else begin
      bus.swap_ready     <= (state_nxt == IDLE);
      bus.swap_done      <= (state_nxt == DONE);
      bus.swap_timeout   <= (state_nxt == TMO);
      bus.ctl_read       <= (state_nxt == POLL_RD);
      bus.ctl_write      <= (state_nxt == WR_BACK) || (state_nxt == WR_SWAP);
      bus.ctl_address    <= 2'd0;
      bus.ctl_byteenable <= 4'h0;
      bus.ctl_writedata  <= 32'h0;
      case (state_nxt)
        WR_BACK: begin
          // Only reachable from IDLE on accept, so the request address is still on swap_addr.
          bus.ctl_address    <= REG_BACK;
          bus.ctl_byteenable <= 4'hF;
          bus.ctl_writedata  <= bus.swap_addr;
        end
        WR_SWAP: begin
          bus.ctl_address    <= REG_FRONT;
          bus.ctl_byteenable <= 4'hF;
          bus.ctl_writedata  <= 32'h1;
        end
        POLL_RD: begin
          bus.ctl_address    <= REG_STATUS;
          bus.ctl_byteenable <= 4'hF;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
